// File: rtl/if_fetch_ctrl.sv
// Fetch-side controller between the PC register and instruction memory.
// Issues one fetch per accepted request, buffers in-order responses, and hands them to decode.
module if_fetch_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic [31:0] next_pc,
  output logic        stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [CW-1:0] ptr_t;
  typedef logic [CW:0]   wide_t;

  localparam ptr_t  DEPTH_P = ptr_t'(DEPTH);
  localparam wide_t DEPTH_W = wide_t'(DEPTH);

  // Pointers carry one extra wrap bit so a full queue is distinguishable from an empty one.
  ptr_t head_q, head_d;
  ptr_t fill_q, fill_d;
  ptr_t alloc_q, alloc_d;
  ptr_t disc_q, disc_d;
  logic [DEPTH-1:0] filled_q, filled_d;

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  ptr_t  count;
  ptr_t  pending;
  ptr_t  owed;
  wide_t outstanding;
  logic  accept;
  logic  resp_drop;
  logic  resp_fill;
  logic  pop;
  logic [PW-1:0] head_idx;
  logic [PW-1:0] fill_idx;
  logic [PW-1:0] alloc_idx;

  assign head_idx    = head_q[PW-1:0];
  assign fill_idx    = fill_q[PW-1:0];
  assign alloc_idx   = alloc_q[PW-1:0];

  assign count       = alloc_q - head_q;
  assign pending     = alloc_q - fill_q;
  assign outstanding = {1'b0, pending} + {1'b0, disc_q};

  // Reset gates the handshake outputs directly so they drop in the same instant reset asserts.
  assign imem_req_valid = reset && !redirect_valid && (count < DEPTH_P) && (outstanding < DEPTH_W);
  assign imem_req_addr  = pc_in;
  assign accept         = imem_req_valid && imem_req_ready;

  assign next_pc = redirect_valid ? redirect_pc : pc_in + 32'd4;
  assign stall   = !reset || !(redirect_valid || accept);

  assign id_valid = reset && filled_q[head_idx] && (count != '0);
  assign id_instr = instr_mem[head_idx];
  assign id_pc    = pc_mem[head_idx];

  assign pop       = id_valid && id_ready && !redirect_valid;
  assign resp_drop = imem_resp_valid && (disc_q != '0);
  // Responses with nothing pending are protocol errors and are ignored.
  assign resp_fill = imem_resp_valid && (disc_q == '0) && (pending != '0) && !redirect_valid;

  // Every response still owed by a flushed request must be swallowed later; one arriving
  // in the redirect cycle itself settles one of those debts right away.
  assign owed = disc_q + pending;

  always_comb begin
    head_d   = head_q;
    fill_d   = fill_q;
    alloc_d  = alloc_q;
    disc_d   = disc_q;
    filled_d = filled_q;
    if (redirect_valid) begin
      head_d   = '0;
      fill_d   = '0;
      alloc_d  = '0;
      filled_d = '0;
      disc_d   = (imem_resp_valid && (owed != '0)) ? owed - ptr_t'(1) : owed;
    end else begin
      if (accept) begin
        alloc_d             = alloc_q + ptr_t'(1);
        filled_d[alloc_idx] = 1'b0;
      end
      if (resp_drop) begin
        disc_d = disc_q - ptr_t'(1);
      end else if (resp_fill) begin
        fill_d             = fill_q + ptr_t'(1);
        filled_d[fill_idx] = 1'b1;
      end
      if (pop) begin
        head_d             = head_q + ptr_t'(1);
        filled_d[head_idx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q   <= '0;
      fill_q   <= '0;
      alloc_q  <= '0;
      disc_q   <= '0;
      filled_q <= '0;
    end else begin
      head_q   <= head_d;
      fill_q   <= fill_d;
      alloc_q  <= alloc_d;
      disc_q   <= disc_d;
      filled_q <= filled_d;
    end
  end

  // Payload storage is qualified by the filled bits, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_mem[alloc_idx] <= pc_in;
    end
    if (resp_fill) begin
      instr_mem[fill_idx] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: a vector table for streaming/backpressure plus
// hand sequences for full queue, redirects, mid-run reset and pc wrap.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic [31:0] next_pc;
  logic        stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;

  logic        pc_load;
  logic [31:0] pc_load_val;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  if_fetch_ctrl #(.DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_in           (pc_in),
    .next_pc         (next_pc),
    .stall           (stall),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .id_valid        (id_valid),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_ready        (id_ready)
  );

  // PC register model: loads next_pc whenever the controller does not stall.
  always @(posedge clk) begin
    if (pc_load) pc_in <= pc_load_val;
    else if (!stall) pc_in <= next_pc;
  end

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        idr;
    logic        e_rv;
    logic [31:0] e_addr;
    logic [31:0] e_npc;
    logic        e_st;
    logic        e_idv;
    logic [31:0] e_idpc;
    logic [31:0] e_idi;
  } vec_t;

  vec_t vt[11];

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rd,
                              input logic idr, input logic e_rv, input logic [31:0] e_addr,
                              input logic [31:0] e_npc, input logic e_st, input logic e_idv,
                              input logic [31:0] e_idpc, input logic [31:0] e_idi);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rd = rd; v.idr = idr;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_npc = e_npc; v.e_st = e_st;
    v.e_idv = e_idv; v.e_idpc = e_idpc; v.e_idi = e_idi;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic idr, input logic rdr, input logic [31:0] rpc);
    imem_req_ready  = rdy;
    imem_resp_valid = rv;
    imem_resp_data  = rd;
    id_ready        = idr;
    redirect_valid  = rdr;
    redirect_pc     = rpc;
  endtask

  task automatic chk_out(input string tag, input logic e_rv, input logic [31:0] e_addr,
                         input logic [31:0] e_npc, input logic e_st, input logic e_idv,
                         input logic [31:0] e_idpc, input logic [31:0] e_idi);
    chk({tag, ".req_valid"}, {31'd0, imem_req_valid}, {31'd0, e_rv});
    chk({tag, ".req_addr"},  imem_req_addr, e_addr);
    chk({tag, ".next_pc"},   next_pc, e_npc);
    chk({tag, ".stall"},     {31'd0, stall}, {31'd0, e_st});
    chk({tag, ".id_valid"},  {31'd0, id_valid}, {31'd0, e_idv});
    if (e_idv) begin
      chk({tag, ".id_pc"},    id_pc, e_idpc);
      chk({tag, ".id_instr"}, id_instr, e_idi);
    end
  endtask

  // One cycle: drive just after the falling edge, check 2 time units later, move to next falling edge.
  task automatic step(input string tag, input logic rdy, input logic rv, input logic [31:0] rd,
                      input logic idr, input logic rdr, input logic [31:0] rpc,
                      input logic e_rv, input logic [31:0] e_addr, input logic [31:0] e_npc,
                      input logic e_st, input logic e_idv, input logic [31:0] e_idpc,
                      input logic [31:0] e_idi);
    drive(rdy, rv, rd, idr, rdr, rpc);
    #2;
    chk_out(tag, e_rv, e_addr, e_npc, e_st, e_idv, e_idpc, e_idi);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag, input logic [31:0] start_pc);
    @(negedge clk);
    reset       = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    pc_load     = 1'b1;
    pc_load_val = start_pc;
    #2;
    chk({tag, ".rst.req_valid"}, {31'd0, imem_req_valid}, 32'd0);
    chk({tag, ".rst.stall"},     {31'd0, stall}, 32'd1);
    chk({tag, ".rst.id_valid"},  {31'd0, id_valid}, 32'd0);
    @(negedge clk);
    pc_load = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset       = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = 32'h0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    //              rdy rv  rd            idr | rv  addr   npc    st  idv id_pc  id_instr
    vt[0]  = mk(1, 0, 32'h0,        1,   1, 32'h00, 32'h04, 0, 0, 32'h0,  32'h0);
    vt[1]  = mk(1, 1, 32'h10000000, 1,   1, 32'h04, 32'h08, 0, 0, 32'h0,  32'h0);
    vt[2]  = mk(0, 1, 32'h10000004, 1,   1, 32'h08, 32'h0C, 1, 1, 32'h00, 32'h10000000);
    vt[3]  = mk(0, 0, 32'h0,        1,   1, 32'h08, 32'h0C, 1, 1, 32'h04, 32'h10000004);
    vt[4]  = mk(0, 0, 32'h0,        1,   1, 32'h08, 32'h0C, 1, 0, 32'h0,  32'h0);
    vt[5]  = mk(1, 0, 32'h0,        1,   1, 32'h08, 32'h0C, 0, 0, 32'h0,  32'h0);
    vt[6]  = mk(1, 1, 32'h10000008, 1,   1, 32'h0C, 32'h10, 0, 0, 32'h0,  32'h0);
    vt[7]  = mk(1, 1, 32'h1000000C, 1,   1, 32'h10, 32'h14, 0, 1, 32'h08, 32'h10000008);
    vt[8]  = mk(0, 1, 32'h10000010, 1,   1, 32'h14, 32'h18, 1, 1, 32'h0C, 32'h1000000C);
    vt[9]  = mk(0, 0, 32'h0,        1,   1, 32'h14, 32'h18, 1, 1, 32'h10, 32'h10000010);
    vt[10] = mk(0, 0, 32'h0,        1,   1, 32'h14, 32'h18, 1, 0, 32'h0,  32'h0);

    // Streaming from reset, then three cycles of imem backpressure at pc 8.
    do_reset("T1", 32'h0);
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].rdy, vt[i].rv, vt[i].rd, vt[i].idr, 1'b0, 32'h0);
      #2;
      chk_out($sformatf("T1.%0d", i), vt[i].e_rv, vt[i].e_addr, vt[i].e_npc, vt[i].e_st,
              vt[i].e_idv, vt[i].e_idpc, vt[i].e_idi);
      @(negedge clk);
    end

    // Decode stalled: queue fills after four requests, a single pop frees one slot.
    do_reset("T3", 32'h0);
    step("T3.0", 1, 0, 32'h0,        0, 0, 32'h0, 1, 32'h00, 32'h04, 0, 0, 32'h0,  32'h0);
    step("T3.1", 1, 1, 32'h10000000, 0, 0, 32'h0, 1, 32'h04, 32'h08, 0, 0, 32'h0,  32'h0);
    step("T3.2", 1, 1, 32'h10000004, 0, 0, 32'h0, 1, 32'h08, 32'h0C, 0, 1, 32'h00, 32'h10000000);
    step("T3.3", 1, 1, 32'h10000008, 0, 0, 32'h0, 1, 32'h0C, 32'h10, 0, 1, 32'h00, 32'h10000000);
    step("T3.4", 1, 1, 32'h1000000C, 0, 0, 32'h0, 0, 32'h10, 32'h14, 1, 1, 32'h00, 32'h10000000);
    step("T3.5", 1, 0, 32'h0,        1, 0, 32'h0, 0, 32'h10, 32'h14, 1, 1, 32'h00, 32'h10000000);
    step("T3.6", 1, 0, 32'h0,        0, 0, 32'h0, 1, 32'h10, 32'h14, 0, 1, 32'h04, 32'h10000004);
    step("T3.7", 1, 0, 32'h0,        0, 0, 32'h0, 0, 32'h14, 32'h18, 1, 1, 32'h04, 32'h10000004);

    // Redirect with two requests in flight; both stale responses are dropped.
    do_reset("T4", 32'h0);
    step("T4.0", 1, 0, 32'h0,        1, 0, 32'h0,   1, 32'h000, 32'h004, 0, 0, 32'h0,   32'h0);
    step("T4.1", 1, 0, 32'h0,        1, 0, 32'h0,   1, 32'h004, 32'h008, 0, 0, 32'h0,   32'h0);
    step("T4.2", 1, 0, 32'h0,        1, 1, 32'h100, 0, 32'h008, 32'h100, 0, 0, 32'h0,   32'h0);
    step("T4.3", 1, 1, 32'hDEAD0000, 1, 0, 32'h0,   1, 32'h100, 32'h104, 0, 0, 32'h0,   32'h0);
    step("T4.4", 0, 1, 32'hDEAD0004, 1, 0, 32'h0,   1, 32'h104, 32'h108, 1, 0, 32'h0,   32'h0);
    step("T4.5", 0, 1, 32'h10000100, 1, 0, 32'h0,   1, 32'h104, 32'h108, 1, 0, 32'h0,   32'h0);
    step("T4.6", 0, 0, 32'h0,        1, 0, 32'h0,   1, 32'h104, 32'h108, 1, 1, 32'h100, 32'h10000100);

    // Redirect coinciding with a response, three pending: exactly two more are dropped.
    do_reset("T5", 32'h0);
    step("T5.0", 1, 0, 32'h0,        1, 0, 32'h0,   1, 32'h000, 32'h004, 0, 0, 32'h0,   32'h0);
    step("T5.1", 1, 0, 32'h0,        1, 0, 32'h0,   1, 32'h004, 32'h008, 0, 0, 32'h0,   32'h0);
    step("T5.2", 1, 0, 32'h0,        1, 0, 32'h0,   1, 32'h008, 32'h00C, 0, 0, 32'h0,   32'h0);
    step("T5.3", 1, 1, 32'hBAD00000, 1, 1, 32'h200, 0, 32'h00C, 32'h200, 0, 0, 32'h0,   32'h0);
    step("T5.4", 0, 1, 32'hBAD00004, 1, 0, 32'h0,   1, 32'h200, 32'h204, 1, 0, 32'h0,   32'h0);
    step("T5.5", 0, 1, 32'hBAD00008, 1, 0, 32'h0,   1, 32'h200, 32'h204, 1, 0, 32'h0,   32'h0);
    step("T5.6", 1, 0, 32'h0,        1, 0, 32'h0,   1, 32'h200, 32'h204, 0, 0, 32'h0,   32'h0);
    step("T5.7", 0, 1, 32'h10000200, 1, 0, 32'h0,   1, 32'h204, 32'h208, 1, 0, 32'h0,   32'h0);
    step("T5.8", 0, 0, 32'h0,        1, 0, 32'h0,   1, 32'h204, 32'h208, 1, 1, 32'h200, 32'h10000200);

    // Reset asserted with three queued entries; fetch resumes from the held pc.
    do_reset("T6", 32'h0);
    step("T6.0", 1, 0, 32'h0,        0, 0, 32'h0, 1, 32'h00, 32'h04, 0, 0, 32'h0, 32'h0);
    step("T6.1", 1, 1, 32'h10000000, 0, 0, 32'h0, 1, 32'h04, 32'h08, 0, 0, 32'h0, 32'h0);
    step("T6.2", 1, 1, 32'h10000004, 0, 0, 32'h0, 1, 32'h08, 32'h0C, 0, 1, 32'h0, 32'h10000000);
    step("T6.3", 0, 1, 32'h10000008, 0, 0, 32'h0, 1, 32'h0C, 32'h10, 1, 1, 32'h0, 32'h10000000);
    reset = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    #2;
    chk("T6.mid.req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("T6.mid.stall",     {31'd0, stall}, 32'd1);
    chk("T6.mid.id_valid",  {31'd0, id_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step("T6.5", 1, 0, 32'h0,        0, 0, 32'h0, 1, 32'h0C, 32'h10, 0, 0, 32'h0,  32'h0);
    step("T6.6", 0, 1, 32'h1000000C, 0, 0, 32'h0, 1, 32'h10, 32'h14, 1, 0, 32'h0,  32'h0);
    step("T6.7", 0, 0, 32'h0,        0, 0, 32'h0, 1, 32'h10, 32'h14, 1, 1, 32'h0C, 32'h1000000C);

    // next_pc wraps from the top of the address space.
    do_reset("T7", 32'hFFFFFFFC);
    step("T7.0", 1, 0, 32'h0, 0, 0, 32'h0, 1, 32'hFFFFFFFC, 32'h0, 0, 0, 32'h0, 32'h0);
    step("T7.1", 0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h00000000, 32'h4, 1, 0, 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
